cc_latch8: RTL
==============

Name: cc_latch8

Overview:
- Condition-code capture stage that sits directly upstream of the eight-input condition multiplexer with control register and drives its d[7:0] bus.
- Synchronizes eight raw status/condition inputs. Each bit is either tracked as a level or captured as a sticky rising-edge event.
- Presents a hold-able registered condition word and lets the microprogram test-and-clear one sticky bit per cycle, selected by the same 3-bit code it gives the mux.

Parameters:
- WIDTH, 8, number of condition bits (the mux requires 8).
- SEL_W, 3, width of the bit-select code (log2 WIDTH).
- SYNC_STAGES, 2, synchronizer flops per raw input (legal range 1..4).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- cin  input  WIDTH  raw asynchronous condition inputs.
- mode_we  input  1  load mode register from mode_d.
- mode_d  input  WIDTH  per-bit mode: 1 = sticky edge capture, 0 = level.
- tclr  input  1  test-and-clear strobe for bit tsel.
- tsel  input  SEL_W  bit index for tclr (same encoding as mux {c,b,a}).
- hold  input  1  freeze output register q.
- q  output  WIDTH  registered condition word, feeds mux d[7:0].
- pending  output  1  registered OR of all sticky-mode state bits.
- mode  output  WIDTH  current mode register (readback).

Behaviour:
- Reset, sampled only on a rising clk edge with rst=1: sync chain, edge-history, state st, mode, q and pending all go to 0. Reset overrides every other input in that cycle. Asserting rst mid-operation discards pending sticky events.
- Synchronizer: cin[i] passes through SYNC_STAGES flops to give s[i]. Edge-history flop h[i] <= s[i]. A rise is detected when s[i]=1 and h[i]=0.
- State update per bit i, evaluated each clock:
  - Level mode (mode[i]=0): st[i] <= s[i]. tclr has no effect.
  - Sticky mode (mode[i]=1), in priority order: rise -> st[i] <= 1. Otherwise tclr=1 with tsel=i -> st[i] <= 0. Otherwise st[i] holds.
  - Simultaneous rise and tclr on the same bit: set wins. The event is not lost.
- Mode: mode_we=1 loads mode_d at the clock edge; the new mode governs st from the following cycle.
  - Changing a bit sticky->level: st follows s from the next cycle.
  - Changing a bit level->sticky: st keeps its current value and then behaves as sticky.
- Output register: when hold=0, q <= st_next, the value st takes at this edge. When hold=1, q holds.
  - st, sync and edge logic keep running under hold, so edges arriving during hold are never dropped.
  - tclr under hold clears st but not q. q picks up the cleared value when hold deasserts.
- pending <= OR over i of (mode_next[i] & st_next[i]). It is registered, updates every cycle, and is unaffected by hold.
- Latency, hold=0: a cin change reaches q exactly SYNC_STAGES+1 clocks later. tclr is visible on q one clock later.
- tsel values >= WIDTH cannot occur (SEL_W=3, WIDTH=8). If WIDTH is overridden smaller, out-of-range tsel is ignored.
- A single-cycle cin pulse shorter than one clock may be missed; the minimum guaranteed-capture pulse width is one clock period.
- All logic is in the clk domain. There are no tri-states; output enable is handled downstream.

Test Plan:
- Reset: drive cin=8'hFF and mode_d=8'hFF with mode_we=1, then assert rst for 1 clk -> next cycle q=8'h00, mode=8'h00, pending=0.
- Level latency: mode=0, SYNC_STAGES=2, cin 8'h00->8'h5A at cycle 0 -> q=8'h00 through cycle 2, q=8'h5A at cycle 3; cin back to 8'h00 -> q=8'h00 three clocks later.
- Sticky capture and clear: mode=8'h01, pulse cin[0] high for 2 clks -> q[0]=1 and pending=1 remain after cin[0] drops; tclr=1 with tsel=0 -> next cycle q[0]=0 and pending=0.
- Set-beats-clear: mode=8'h80, time tclr with tsel=7 to land on the same edge as the detected rise of cin[7] -> q[7]=1 and pending=1 after that edge.
- Hold: hold=1 with q=8'h00 and mode=8'h04, pulse cin[2] -> q stays 8'h00 and pending=1; release hold -> q=8'h04 on the next clock.
- Mode switch: mode=8'hFF with st=8'h10 captured, cin=8'h00, write mode_d=8'h00 -> q=8'h00 two clocks after mode_we, pending=0.

Source files
------------

// File: rtl/cc_latch8.sv
// Condition-code capture stage: synchronizes raw conditions, tracks each bit as a
// level or a sticky rising-edge event, and presents a hold-able registered word.
module cc_latch8 #(
  parameter int WIDTH       = 8,
  parameter int SEL_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cin,
  input  logic             mode_we,
  input  logic [WIDTH-1:0] mode_d,
  input  logic             tclr,
  input  logic [SEL_W-1:0] tsel,
  input  logic             hold,
  output logic [WIDTH-1:0] q,
  output logic             pending,
  output logic [WIDTH-1:0] mode
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] st;
  logic [WIDTH-1:0] st_next;
  logic [WIDTH-1:0] mode_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      h <= '0;
    end else begin
      sync_q[0] <= cin;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      h <= s;
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~h;
  assign mode_next = mode_we ? mode_d : mode;

  // The mode in force before this edge governs st; a rise beats a same-cycle clear.
  always_comb begin
    st_next = st;
    for (int i = 0; i < WIDTH; i++) begin
      if (!mode[i]) begin
        st_next[i] = s[i];
      end else if (rise[i]) begin
        st_next[i] = 1'b1;
      end else if (tclr && (tsel == SEL_W'(i))) begin
        st_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= '0;
      mode    <= '0;
      q       <= '0;
      pending <= 1'b0;
    end else begin
      st      <= st_next;
      mode    <= mode_next;
      pending <= |(mode_next & st_next);
      if (!hold) q <= st_next;
    end
  end

endmodule
